// File: rtl/proc_pkg.sv
// Shared types for the Proc sequencer: FSM states, opcode encodings, op classes.
package proc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_MUL_WAIT, ST_WB, ST_TRAP
  } state_e;

  localparam logic [6:0] OPC_ALU    = 7'h00;
  localparam logic [6:0] OPC_MUL    = 7'h02;
  localparam logic [6:0] OPC_LOAD   = 7'h10;
  localparam logic [6:0] OPC_STORE  = 7'h11;
  localparam logic [6:0] OPC_BRANCH = 7'h30;

  typedef enum logic [2:0] {
    OP_ALU, OP_MUL, OP_LOAD, OP_STORE, OP_BRANCH, OP_ILL
  } op_e;

  function automatic op_e op_class(input logic [6:0] opc);
    case (opc)
      OPC_ALU:    return OP_ALU;
      OPC_MUL:    return OP_MUL;
      OPC_LOAD:   return OP_LOAD;
      OPC_STORE:  return OP_STORE;
      OPC_BRANCH: return OP_BRANCH;
      default:    return OP_ILL;
    endcase
  endfunction

endpackage

// File: rtl/proc_wait_timer.sv
// Wait-cycle counter for memory handshakes; expired flags the miss that reaches LIMIT.
module proc_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic cnt,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (cnt && cnt_q != CW'(LIMIT))
      cnt_d = cnt_q + CW'(1);
  end

  // Fires in the cycle whose miss would make the count reach LIMIT, so a
  // valid arriving in that same cycle still wins.
  assign expired = cnt && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/proc_seq_ctrl.sv
// Multi-cycle Proc sequencer: fetch/decode/exec/mem/mul/write-back FSM, owns PC, IR,
// retired-instruction count, and a sticky trap on illegal op, bad branch or memory timeout.
module proc_seq_ctrl
  import proc_pkg::*;
#(
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_PC    = 32'h1000,
  parameter int              MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ir_out,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_valid,
  output logic            mul_start,
  input  logic            mul_done,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic            rf_we,
  output logic            y_sel,
  output logic [PC_W-1:0] pc,
  output logic            retire,
  output logic [31:0]     instret,
  output logic            trap
);

  state_e          st_q, st_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [31:0]     ir_q, ir_d;
  logic [31:0]     instret_q, instret_d;
  logic            imem_req_q, imem_req_d;
  logic            dmem_req_q, dmem_req_d;
  logic            dmem_we_q, dmem_we_d;
  logic            mul_start_q, mul_start_d;
  logic            rf_we_q, rf_we_d;
  logic            y_sel_q, y_sel_d;
  logic            retire_q, retire_d;
  logic            trap_q, trap_d;
  logic            tmr_clr, tmr_cnt, tmr_exp;
  op_e             op;

  assign op     = op_class(ir_q[31:25]);
  assign pc_inc = pc_q + PC_W'(4);

  // Counting only while the request is actually on the bus keeps the
  // post-reset idle FETCH cycle out of the timeout budget.
  assign tmr_cnt = (st_q == ST_FETCH && imem_req_q && !imem_valid) ||
                   (st_q == ST_MEM   && dmem_req_q && !dmem_valid);
  assign tmr_clr = (st_d != st_q);

  proc_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (tmr_clr),
    .cnt     (tmr_cnt),
    .expired (tmr_exp)
  );

  always_comb begin
    st_d      = st_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    retire_d  = 1'b0;
    case (st_q)
      ST_FETCH: begin
        if (imem_req_q && imem_valid) begin
          ir_d = imem_rdata;
          st_d = ST_DECODE;
        end else if (tmr_exp) begin
          st_d = ST_TRAP;
        end
      end
      ST_DECODE: st_d = (op == OP_ILL) ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        case (op)
          OP_ALU:            st_d = ST_WB;
          OP_LOAD, OP_STORE: st_d = ST_MEM;
          OP_MUL:            st_d = ST_MUL_WAIT;
          OP_BRANCH: begin
            if (br_taken && br_target[1:0] != 2'b00) begin
              st_d = ST_TRAP;
            end else begin
              pc_d      = br_taken ? br_target : pc_inc;
              retire_d  = 1'b1;
              instret_d = instret_q + 32'd1;
              st_d      = ST_FETCH;
            end
          end
          default:           st_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (dmem_req_q && dmem_valid) begin
          if (op == OP_STORE) begin
            pc_d      = pc_inc;
            retire_d  = 1'b1;
            instret_d = instret_q + 32'd1;
            st_d      = ST_FETCH;
          end else begin
            st_d = ST_WB;
          end
        end else if (tmr_exp) begin
          st_d = ST_TRAP;
        end
      end
      ST_MUL_WAIT: if (mul_done) st_d = ST_WB;
      ST_WB: begin
        pc_d      = pc_inc;
        retire_d  = 1'b1;
        instret_d = instret_q + 32'd1;
        st_d      = ST_FETCH;
      end
      default: st_d = ST_TRAP;
    endcase

    // Outputs are registered from the next state so they line up with it.
    imem_req_d  = (st_d == ST_FETCH);
    dmem_req_d  = (st_d == ST_MEM);
    dmem_we_d   = (st_d == ST_MEM) && (op == OP_STORE);
    mul_start_d = (st_d == ST_EXEC) && (op == OP_MUL);
    rf_we_d     = (st_d == ST_WB);
    y_sel_d     = (st_d == ST_WB) && (op != OP_ALU);
    trap_d      = (st_d == ST_TRAP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q        <= ST_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      instret_q   <= '0;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      mul_start_q <= 1'b0;
      rf_we_q     <= 1'b0;
      y_sel_q     <= 1'b0;
      retire_q    <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      instret_q   <= instret_d;
      imem_req_q  <= imem_req_d;
      dmem_req_q  <= dmem_req_d;
      dmem_we_q   <= dmem_we_d;
      mul_start_q <= mul_start_d;
      rf_we_q     <= rf_we_d;
      y_sel_q     <= y_sel_d;
      retire_q    <= retire_d;
      trap_q      <= trap_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign ir_out    = ir_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign mul_start = mul_start_q;
  assign rf_we     = rf_we_q;
  assign y_sel     = y_sel_q;
  assign pc        = pc_q;
  assign retire    = retire_q;
  assign instret   = instret_q;
  assign trap      = trap_q;

endmodule
